// File: rtl/clk_div_monitor.sv
// clk_div_monitor
//   Watches the divided clock from the even clock divider. Both run on iclk, so
//   div_clk is sampled directly. The monitor measures the high and low phase
//   lengths in iclk samples and compares each one with DIVISOR/2. It asserts
//   locked after LOCK_COUNT consecutive good periods. It raises sticky errors
//   for a bad period while locked and for a stuck clock.
// Ports
//   iclk          system clock, all logic on posedge
//   rst           asynchronous active-low reset
//   en            monitor enable; low forces IDLE (sticky errors kept)
//   div_clk       divided clock under test
//   err_clr       one-cycle pulse clearing err_duty / err_stuck
//   high_cnt      last measured high-phase length
//   low_cnt       last measured low-phase length
//   period_valid  one-cycle pulse, new high/low pair complete
//   period_ok     that pair was DIVISOR/2 each
//   locked        LOCK_COUNT good periods in a row, no fault since
//   err_duty      sticky, bad period seen while locked
//   err_stuck     sticky, no edge for DIVISOR samples while acquiring/locked
module clk_div_monitor #(
   parameter int DIVISOR    = 4,
   parameter int LOCK_COUNT = 4,
   localparam int CNT_W     = $clog2(DIVISOR + 1)
) (
   input  logic             iclk,
   input  logic             rst,
   input  logic             en,
   input  logic             div_clk,
   input  logic             err_clr,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] low_cnt,
   output logic             period_valid,
   output logic             period_ok,
   output logic             locked,
   output logic             err_duty,
   output logic             err_stuck
);

   localparam int HALF = DIVISOR / 2;
   localparam int GW   = $clog2(LOCK_COUNT + 1);

   if (DIVISOR < 2 || (DIVISOR % 2) != 0) begin : g_bad_divisor
      $error("clk_div_monitor: DIVISOR must be even and >= 2");
   end
   if (LOCK_COUNT < 1) begin : g_bad_lock_count
      $error("clk_div_monitor: LOCK_COUNT must be >= 1");
   end

   typedef enum logic [1:0] {IDLE, SYNC, ACQ, LOCKED} state_t;

   state_t           st;
   logic             d_q;
   logic [CNT_W-1:0] phase_cnt;
   logic [GW-1:0]    good_cnt;
   logic             have_high;

   logic             edge_s, rise, fall, active, good, stuck, duty_set;
   logic [CNT_W-1:0] nxt_phase;

   always_comb begin
      edge_s    = div_clk ^ d_q;
      rise      = edge_s & div_clk;
      fall      = edge_s & ~div_clk;
      active    = en && (st == ACQ || st == LOCKED);
      // The low phase being closed is still in phase_cnt on this sample.
      good      = (high_cnt == CNT_W'(HALF)) && (phase_cnt == CNT_W'(HALF));
      stuck     = active && !edge_s && (phase_cnt == CNT_W'(DIVISOR));
      duty_set  = active && (st == LOCKED) && rise && have_high && !good;
      nxt_phase = phase_cnt;
      if (edge_s)
         nxt_phase = CNT_W'(1);
      else if (phase_cnt != {CNT_W{1'b1}})
         nxt_phase = phase_cnt + CNT_W'(1);
   end

   always_ff @(posedge iclk or negedge rst) begin
      if (!rst) begin
         st           <= IDLE;
         d_q          <= 1'b0;
         phase_cnt    <= '0;
         good_cnt     <= '0;
         have_high    <= 1'b0;
         high_cnt     <= '0;
         low_cnt      <= '0;
         period_valid <= 1'b0;
         period_ok    <= 1'b0;
         locked       <= 1'b0;
         err_duty     <= 1'b0;
         err_stuck    <= 1'b0;
      end else begin
         d_q          <= div_clk;
         period_valid <= 1'b0;
         // A fault in the same cycle as err_clr wins.
         err_duty     <= duty_set | (err_duty  & ~err_clr);
         err_stuck    <= stuck    | (err_stuck & ~err_clr);

         if (!en) begin
            st        <= IDLE;
            phase_cnt <= '0;
            good_cnt  <= '0;
            have_high <= 1'b0;
            locked    <= 1'b0;
         end else begin
            phase_cnt <= nxt_phase;
            case (st)
               IDLE: st <= SYNC;
               // The first edge ends a partial phase of unknown length. Drop it.
               SYNC: if (edge_s) st <= ACQ;
               ACQ, LOCKED: begin
                  if (stuck) begin
                     st        <= SYNC;
                     locked    <= 1'b0;
                     have_high <= 1'b0;
                     good_cnt  <= '0;
                  end else if (fall) begin
                     high_cnt  <= phase_cnt;
                     have_high <= 1'b1;
                  end else if (rise) begin
                     low_cnt <= phase_cnt;
                     if (have_high) begin
                        period_valid <= 1'b1;
                        period_ok    <= good;
                        if (good) begin
                           if (st == ACQ) begin
                              good_cnt <= good_cnt + GW'(1);
                              if (good_cnt == GW'(LOCK_COUNT - 1)) begin
                                 st     <= LOCKED;
                                 locked <= 1'b1;
                              end
                           end
                        end else begin
                           good_cnt <= '0;
                           locked   <= 1'b0;
                           st       <= ACQ;
                        end
                     end
                  end
               end
               default: st <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_clk_div_monitor.sv
module tb_clk_div_monitor;

   typedef struct {
      int h;
      int l;
      int ok;
      int lk;
   } exp_t;

   logic       iclk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0, div_clk = 1'b0, err_clr = 1'b0;
   logic [2:0] high_cnt, low_cnt;
   logic       period_valid, period_ok, locked, err_duty, err_stuck;

   logic       en2 = 1'b0, dclk2 = 1'b0, clr2 = 1'b0;
   logic [1:0] hc2, lc2;
   logic       pv2, pok2, lk2, ed2, es2;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t me;

   always #5 iclk = ~iclk;

   clk_div_monitor #(.DIVISOR(4), .LOCK_COUNT(4)) dut4 (
      .iclk(iclk), .rst(rst), .en(en), .div_clk(div_clk), .err_clr(err_clr),
      .high_cnt(high_cnt), .low_cnt(low_cnt), .period_valid(period_valid),
      .period_ok(period_ok), .locked(locked), .err_duty(err_duty), .err_stuck(err_stuck));

   clk_div_monitor #(.DIVISOR(2), .LOCK_COUNT(4)) dut2 (
      .iclk(iclk), .rst(rst), .en(en2), .div_clk(dclk2), .err_clr(clr2),
      .high_cnt(hc2), .low_cnt(lc2), .period_valid(pv2),
      .period_ok(pok2), .locked(lk2), .err_duty(ed2), .err_stuck(es2));

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: each period_valid pulse must match the oldest expectation.
   always @(posedge iclk) begin
      #1;
      if (period_valid === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: period_valid=1 with no expected period at %0t", $time);
         end else begin
            me = q.pop_front();
            check("mon_high_cnt", int'(high_cnt), me.h);
            check("mon_low_cnt", int'(low_cnt), me.l);
            check("mon_period_ok", int'(period_ok), me.ok);
            check("mon_locked", int'(locked), me.lk);
         end
      end
   end

   // Called at a negedge. Holds div_clk for n samples and returns at a negedge.
   task automatic drive(input logic lvl, input int n);
      div_clk = lvl;
      repeat (n) @(negedge iclk);
   endtask

   // One high/low period. The expectation is pushed before the rising edge that closes it.
   task automatic hl(input int h, input int l, input bit push, input int ok, input int lk);
      drive(1'b1, h);
      drive(1'b0, l);
      if (push) q.push_back('{h, l, ok, lk});
   endtask

   task automatic chk_all_zero(input string tag);
      check({tag, "_high_cnt"}, int'(high_cnt), 0);
      check({tag, "_low_cnt"}, int'(low_cnt), 0);
      check({tag, "_period_valid"}, int'(period_valid), 0);
      check({tag, "_period_ok"}, int'(period_ok), 0);
      check({tag, "_locked"}, int'(locked), 0);
      check({tag, "_err_duty"}, int'(err_duty), 0);
      check({tag, "_err_stuck"}, int'(err_stuck), 0);
      check({tag, "_locked2"}, int'(lk2), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge iclk);
      chk_all_zero("reset");
      rst = 1'b1;
      @(negedge iclk);

      // DIVISOR=2, alternating samples lock after four pulses.
      en2 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge iclk);
         dclk2 = ~dclk2;
      end
      check("d2_locked", int'(lk2), 1);
      check("d2_high_cnt", int'(hc2), 1);
      check("d2_low_cnt", int'(lc2), 1);
      check("d2_period_ok", int'(pok2), 1);
      check("d2_err_stuck", int'(es2), 0);
      check("d2_err_duty", int'(ed2), 0);
      en2 = 1'b0;

      // Clean 0011 pattern: the first rising edge only syncs, lock on the 4th pulse.
      en = 1'b1;
      drive(1'b0, 2);
      hl(2, 2, 1, 1, 0);
      hl(2, 2, 1, 1, 0);
      hl(2, 2, 1, 1, 0);
      check("t1_not_locked_yet", int'(locked), 0);
      hl(2, 2, 1, 1, 1);
      hl(2, 2, 1, 1, 1);
      check("t1_locked", int'(locked), 1);
      check("t1_err_duty", int'(err_duty), 0);

      // Stretched high phase while locked.
      hl(3, 2, 1, 0, 0);
      hl(2, 2, 1, 1, 0);
      check("t2_err_duty", int'(err_duty), 1);
      check("t2_unlocked", int'(locked), 0);
      hl(2, 2, 1, 1, 0);
      hl(2, 2, 1, 1, 0);
      hl(2, 2, 1, 1, 1);
      hl(2, 2, 1, 1, 1);
      check("t2_relocked", int'(locked), 1);

      // Stuck high: the 5th sample at the same level is the fault.
      drive(1'b1, 8);
      check("t3_err_stuck", int'(err_stuck), 1);
      check("t3_unlocked", int'(locked), 0);
      check("t3_err_duty_kept", int'(err_duty), 1);
      drive(1'b0, 2);
      hl(2, 2, 1, 1, 0);
      hl(2, 2, 1, 1, 0);
      hl(2, 2, 1, 1, 0);
      hl(2, 2, 1, 1, 1);
      hl(2, 2, 1, 1, 1);
      check("t3_relocked", int'(locked), 1);

      // Enable drop mid-period.
      drive(1'b1, 1);
      en = 1'b0;
      drive(1'b1, 1);
      check("t6_unlocked", int'(locked), 0);
      check("t6_err_duty_kept", int'(err_duty), 1);
      check("t6_err_stuck_kept", int'(err_stuck), 1);
      drive(1'b0, 1);
      drive(1'b1, 1);
      drive(1'b0, 1);
      check("t6_no_pulse", int'(period_valid), 0);

      // err_clr pulse alone.
      err_clr = 1'b1;
      @(negedge iclk);
      err_clr = 1'b0;
      check("t4_clr_duty", int'(err_duty), 0);
      check("t4_clr_stuck", int'(err_stuck), 0);

      // err_clr on the same sample as a stuck fault: the set wins.
      en = 1'b1;
      drive(1'b0, 2);
      drive(1'b1, 4);
      check("t4_no_stuck_yet", int'(err_stuck), 0);
      err_clr = 1'b1;
      drive(1'b1, 1);
      err_clr = 1'b0;
      check("t4_set_wins", int'(err_stuck), 1);
      check("t4_duty_still_clear", int'(err_duty), 0);

      // Relock, then reset asynchronously between clock edges.
      drive(1'b0, 2);
      hl(2, 2, 1, 1, 0);
      hl(2, 2, 1, 1, 0);
      hl(2, 2, 1, 1, 0);
      hl(2, 2, 1, 1, 1);
      hl(2, 2, 0, 1, 1);
      check("t5_locked_before_rst", int'(locked), 1);
      #2 rst = 1'b0;
      #1 chk_all_zero("t5_async");
      @(negedge iclk);
      rst = 1'b1;
      // After release the FSM waits in SYNC; a dead clock raises nothing there.
      drive(1'b1, 12);
      check("t5_sync_no_stuck", int'(err_stuck), 0);
      check("t5_sync_unlocked", int'(locked), 0);
      check("t5_queue_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
